// File: rtl/avalon_st_packet_arbiter.sv
// avalon_st_packet_arbiter: round-robin packet-boundary Avalon-ST arbiter (clk, rst, in_*, out_*, grant_idx; drop_count when AVALON_ARB_DROP_CNT_EN)
module avalon_st_packet_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS-1:0]              in_sop,
  input  logic [NUM_INPUTS-1:0]              in_eop,
  output logic [NUM_INPUTS-1:0]              in_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_sop,
  output logic                               out_eop,
  input  logic                               out_ready,
  output logic [$clog2(NUM_INPUTS)-1:0]      grant_idx
`ifdef AVALON_ARB_DROP_CNT_EN
  , output logic [15:0]                      drop_count
`endif
);
  localparam int GW = $clog2(NUM_INPUTS);
  typedef enum logic {ARB_IDLE = 1'b0, ARB_PASS = 1'b1} state_t;
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, rr_n, grant_n, sel, idx;
  logic [NUM_INPUTS-1:0] req, drop;
  logic [DATA_WIDTH-1:0] lane [NUM_INPUTS];
  logic rst_q;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign lane[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_n;
      rr_ptr    <= rr_n;
    end
  end
  always_ff @(posedge clk) rst_q <= rst;
  always_comb begin
    req  = in_valid & in_sop;
    drop = (state == ARB_IDLE && !rst_q) ? in_valid & ~in_sop : '0;
    sel  = '0;
    idx  = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_INPUTS);
      sel = req[idx] ? idx : sel;
    end
    state_n   = state;
    grant_n   = grant_idx;
    rr_n      = rr_ptr;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    in_ready  = drop;
    if (state == ARB_PASS) begin
      out_valid           = in_valid[grant_idx];
      out_sop             = in_sop[grant_idx];
      out_eop             = in_eop[grant_idx];
      out_data            = lane[grant_idx];
      in_ready            = '0;
      in_ready[grant_idx] = out_ready;
      if (out_valid && out_ready && out_eop) begin
        state_n = ARB_IDLE;
        rr_n    = (grant_idx == GW'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (|req) begin
      state_n = ARB_PASS;
      grant_n = sel;
    end
  end
`ifdef AVALON_ARB_DROP_CNT_EN
  logic [16:0] drop_sum;
  always_comb begin
    drop_sum = {1'b0, drop_count};
    for (int k = 0; k < NUM_INPUTS; k++) drop_sum = drop_sum + 17'(drop[k]);
  end
  always_ff @(posedge clk) drop_count <= rst ? '0 : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
`endif
endmodule
